// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the mac_sched round-robin MAC scheduler.
// Optional watchdog selected by the MAC_SCHED_TIMEOUT_EN macro (see mac_sched.sv).
package mac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int OP_W        = 4;
    localparam int RES_W       = 11;
    localparam int GROUP_DEF   = 8;
    localparam int TIMEOUT_LIM = 16;

    // Signed 4x4 product, sign-extended to the accumulator width.
    function automatic logic signed [RES_W-1:0] mul_sext(input logic signed [OP_W-1:0] a,
                                                         input logic signed [OP_W-1:0] b);
        logic signed [2*OP_W-1:0] p;
        p = (2*OP_W)'(a) * (2*OP_W)'(b);
        return RES_W'(p);
    endfunction

endpackage

// File: rtl/mac_sched_acc.sv
// Shared MAC datapath: sign-extending multiplier, 11-bit accumulator and pair counter.
// 'last' flags the enabled cycle that carries the final pair of a group.
module mac_sched_acc
    import mac_sched_pkg::*;
#(
    parameter int GROUP = GROUP_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    output logic signed [RES_W-1:0] sum,
    output logic                    last
);

    localparam int CNT_W = $clog2(GROUP + 1);

    logic signed [RES_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    // sum is the value acc takes on an enabled edge, so the final result can be
    // registered by the scheduler on the same edge that accepts the last pair.
    assign sum  = acc + mul_sext(a, b);
    assign last = en && (cnt == CNT_W'(GROUP - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one signed MAC across NREQ requesters.
// Define MAC_SCHED_TIMEOUT_EN to abort groups stalled for TIMEOUT_LIM cycles.
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int GROUP = GROUP_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [OP_W*NREQ-1:0]       req_a,
    input  logic [OP_W*NREQ-1:0]       req_b,
    output logic [NREQ-1:0]            gnt,
    output logic signed [RES_W-1:0]    res_out,
    output logic [$clog2(NREQ)-1:0]    res_id,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       busy,
    output logic                       abort
);

    localparam int ID_W = $clog2(NREQ);

    state_t                  state;
    logic [ID_W-1:0]         g;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         pick;
    logic                    pick_vld;
    int                      cand;
    logic                    accept;
    logic                    timeout;
    logic                    last;
    logic signed [OP_W-1:0]  a_sel;
    logic signed [OP_W-1:0]  b_sel;
    logic signed [RES_W-1:0] sum;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(rr_ptr) + i) % NREQ;
            if (!pick_vld && req[cand]) begin
                pick     = ID_W'(cand);
                pick_vld = 1'b1;
            end
        end
    end

    assign a_sel  = req_a[OP_W*int'(g) +: OP_W];
    assign b_sel  = req_b[OP_W*int'(g) +: OP_W];
    // A dropped req wins over a pair in the same cycle.
    assign accept = (state == ACCUM) && req[g] && req_valid[g];
    assign busy   = (state != IDLE);

    mac_sched_acc #(.GROUP(GROUP)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != ACCUM),
        .en      (accept),
        .a       (a_sel),
        .b       (b_sel),
        .sum     (sum),
        .last    (last)
    );

`ifdef MAC_SCHED_TIMEOUT_EN
    logic [4:0] idle_cnt;

    assign timeout = !accept && (idle_cnt == 5'(TIMEOUT_LIM - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (state != ACCUM || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 5'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            g         <= '0;
            rr_ptr    <= '0;
            res_out   <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= NREQ'(1) << pick;
                        g     <= pick;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!req[g] || timeout) begin
                        abort  <= 1'b1;
                        gnt    <= '0;
                        rr_ptr <= next_id(g);
                        state  <= IDLE;
                    end else if (last) begin
                        res_out   <= sum;
                        res_id    <= g;
                        res_valid <= 1'b1;
                        gnt       <= '0;
                        rr_ptr    <= next_id(g);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_sched.md
# mac_sched

Round-robin scheduler that shares one signed 4-bit multiply-accumulate datapath between NREQ requesters. Each granted requester streams one group of GROUP operand pairs. The block accumulates them in its MAC sub-module and returns one 11-bit signed result tagged with the requester index. It sits between the requesting stages and the result consumer, and replaces per-requester MAC instances.

## Interface
- NREQ, 4, number of requesters (2..8)
- GROUP, 8, operand pairs per accumulation group
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester group request, level
- req_valid  in  NREQ  per-requester operand pair valid
- req_a  in  4*NREQ  signed operand a, requester i at [4i+3:4i]
- req_b  in  4*NREQ  signed operand b, same packing
- gnt  out  NREQ  one-hot grant; a pair is accepted while gnt[i] & req_valid[i]
- res_out  out  11  signed accumulated result
- res_id  out  clog2(NREQ)  requester index of res_out
- res_valid  out  1  result valid, held until res_ready
- res_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE
- abort  out  1  one-cycle pulse when a group is discarded

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE, any req bit high:
  - Pick the first set bit at or after rr_ptr, wrapping.
  - Next edge: gnt one-hot, cnt=0, acc=0, go to ACCUM.
- ACCUM, per edge with req_valid[g]:
  - acc += sext(a)*sext(b).
  - cnt += 1.
  - req_valid of non-granted requesters is ignored.
- ACCUM, edge accepting pair GROUP:
  - res_out = final sum, res_id = g, res_valid=1.
  - gnt cleared, rr_ptr = g+1 mod NREQ, go to DONE.
- ACCUM, req[g] low at an edge:
  - Group discarded; a pair in the same cycle is not accepted.
  - Pulse abort, clear gnt, rr_ptr = g+1, go to IDLE.
- DONE:
  - res_out, res_id and res_valid are held stable until an edge with res_ready=1.
  - On that edge: res_valid=0, go to IDLE.
- Arithmetic: products span -56..64; the 8-pair sum spans -448..512. acc is 11-bit signed and cannot overflow at GROUP=8.
- Reset values:
  - gnt=0, res_out=0, res_id=0, res_valid=0, busy=0, abort=0.
  - rr_ptr=0, so requester 0 wins first.
  - cnt=0, acc=0, state IDLE.
- Reset mid-group discards all accumulation state; no result is produced.

## Timing
- Request to grant: req sampled high in IDLE gives gnt high after 1 edge.
- Result latency: res_valid rises on the edge that accepts the GROUP-th pair.
  - With req_valid held high, gnt rises edge 0 and res_valid rises edge GROUP.
- Back-to-back: the earliest next gnt comes 1 cycle after the res_ready handshake edge (IDLE lasts 1 cycle).
- Simultaneous requests: round-robin from rr_ptr. A lone requester is re-granted immediately after its own result.
- req_valid gaps in ACCUM stall cnt without penalty.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- MAC_SCHED_TIMEOUT_EN defined:
  - A 5-bit idle counter runs in ACCUM and resets on each accepted pair.
  - After 16 consecutive cycles without an accepted pair, the group is discarded as on req drop (abort pulse, IDLE, rr_ptr advanced).
- MAC_SCHED_TIMEOUT_EN undefined: no watchdog; ACCUM waits indefinitely. abort fires only on req drop.

## Structure
- Package mac_sched_pkg:
  - State enum (IDLE/ACCUM/DONE).
  - Operand width 4, result width 11, default GROUP 8, timeout limit 16.
- Sub-module mac_sched_acc: sign-extending multiplier plus 11-bit accumulator with clear, enable and pair counter; signals last-pair.
- Arbitration and FSM live in mac_sched.

## Test plan
- Single requester: req[1]=1, 8 pairs a=3, b=-2 back-to-back. Expect gnt=0010 after 1 edge, res_out=-48, res_id=1, res_valid on edge 8.
- Extremes: requester 0 sends 8 pairs a=-8, b=-8. Expect res_out=512; then 8 pairs a=-8, b=7, expect res_out=-448. No overflow.
- Contention: req=1111 held, each group a=1, b=i+1. Expect grant order 0,1,2,3,0 and res_out=8,16,24,32,8.
- Backpressure: res_ready=0 for 5 cycles after res_valid. Expect res_out and res_id stable, no new gnt until 1 cycle after the handshake.
- Abort: drop req[2] after 3 pairs. Expect an abort pulse, no res_valid, rr_ptr=3, next grant to requester 3.
- Watchdog, built with MAC_SCHED_TIMEOUT_EN: granted requester stops req_valid after 2 pairs. Expect abort after 16 idle cycles. Without the macro, busy stays high.
- Reset: assert reset_n=0 mid-group. Expect all outputs 0 immediately; a fresh group after release yields the correct sum.
